// File: rtl/round_ctrl_pkg.sv
// round_ctrl shared types: state encoding,
// letter/word widths and output counter widths.
package round_ctrl_pkg;
  localparam int LETTER_W = 5;
  localparam int WORD_W   = 4 * LETTER_W;
  localparam int SCORE_W  = 6;
  localparam int LIVES_W  = 2;
  localparam int TIME_W   = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_DONE
  } state_t;
endpackage

// File: rtl/round_timer.sv
// Game-time down-counter. load presets ROUND_SECS, tick
// decrements (floor 0), expire flags the tick reaching 0.
module round_timer
  import round_ctrl_pkg::*;
#(
  parameter int ROUND_SECS = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              tick,
  output logic              expire,
  output logic [TIME_W-1:0] count
);

  localparam logic [TIME_W-1:0] INIT =
    TIME_W'(ROUND_SECS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= INIT;
    end else if (load) begin
      count <= INIT;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = tick && !load &&
                  (count <= TIME_W'(1));

endmodule

// File: rtl/round_ctrl.sv
// Word-game round controller: fetches words, tracks score,
// lives and time. Ports: start/tick/pass/fail/word_data in;
// word_addr, cword, chk_clr, score, lives, time_left,
// playing, game_over out. ROUND_CTRL_TIMER_EN enables timer.
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter int NWORDS     = 32,
  parameter int LIVES      = 3,
  parameter int ROUND_SECS = 60,
  localparam int AW        = $clog2(NWORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tick,
  input  logic               pass,
  input  logic               fail,
  input  logic [WORD_W-1:0]  word_data,
  output logic [AW-1:0]      word_addr,
  output logic [WORD_W-1:0]  cword,
  output logic               chk_clr,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [TIME_W-1:0]  time_left,
  output logic               playing,
  output logic               game_over
);

  localparam logic [LIVES_W-1:0] LIVES_INIT =
    LIVES_W'(LIVES);

  state_t state;
  logic   active;
  logic   load;
  logic   tick_act;
  logic   expire;

  assign active   = (state == S_FETCH) ||
                    (state == S_LATCH) ||
                    (state == S_PLAY);
  assign load     = (state == S_IDLE) && start;
  assign tick_act = tick && active;

`ifdef ROUND_CTRL_TIMER_EN
  round_timer #(
    .ROUND_SECS(ROUND_SECS)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .tick   (tick_act),
    .expire (expire),
    .count  (time_left)
  );
`else
  wire unused_tick = tick_act;
  assign time_left = '0;
  assign expire    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      word_addr <= '0;
      cword     <= '0;
      chk_clr   <= 1'b0;
      score     <= '0;
      lives     <= LIVES_INIT;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      chk_clr <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            score <= '0;
            lives <= LIVES_INIT;
          end
        end
        S_FETCH: begin
          if (expire) begin
            state     <= S_DONE;
            game_over <= 1'b1;
          end else begin
            state   <= S_LATCH;
            chk_clr <= 1'b1;
          end
        end
        S_LATCH: begin
          // word_data now reflects word_addr
          cword <= word_data;
          if (expire) begin
            state     <= S_DONE;
            game_over <= 1'b1;
          end else begin
            state   <= S_PLAY;
            playing <= 1'b1;
          end
        end
        S_PLAY: begin
          if (fail) begin
            lives <= lives - 1'b1;
            if (lives == LIVES_W'(1) || expire) begin
              state     <= S_DONE;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end else begin
              word_addr <= word_addr + 1'b1;
              state     <= S_FETCH;
              playing   <= 1'b0;
            end
          end else if (pass) begin
            if (score != '1)
              score <= score + 1'b1;
            word_addr <= word_addr + 1'b1;
            playing   <= 1'b0;
            if (expire) begin
              state     <= S_DONE;
              game_over <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end else if (expire) begin
            state     <= S_DONE;
            playing   <= 1'b0;
            game_over <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state     <= S_IDLE;
            game_over <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: table of game actions
// plus hand sequences for latency, timer and reset.
module tb_round_ctrl;
  import round_ctrl_pkg::*;

  localparam int NW = 4;
  localparam int LV = 3;
  localparam int RS = 2;

`ifdef ROUND_CTRL_TIMER_EN
  localparam int T_RST = RS;
`else
  localparam int T_RST = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              start, tick, pass, fail;
  logic [WORD_W-1:0] word_data;
  logic [1:0]        word_addr;
  logic [WORD_W-1:0] cword;
  logic              chk_clr;
  logic [5:0]        score;
  logic [1:0]        lives;
  logic [6:0]        time_left;
  logic              playing;
  logic              game_over;

  logic [WORD_W-1:0] mem [NW];

  int nvec = 0;
  int nerr = 0;

  round_ctrl #(
    .NWORDS(NW), .LIVES(LV), .ROUND_SECS(RS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tick(tick), .pass(pass), .fail(fail),
    .word_data(word_data), .word_addr(word_addr),
    .cword(cword), .chk_clr(chk_clr),
    .score(score), .lives(lives),
    .time_left(time_left), .playing(playing),
    .game_over(game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) word_data <= mem[word_addr];

  typedef enum {OP_START, OP_PASS, OP_FAIL, OP_BOTH} op_t;
  typedef struct {
    op_t op;
    int  score;
    int  lives;
    int  addr;
    int  play;
    int  over;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm,
                     input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic p,
                       input logic f, input logic t);
    start = s; pass = p; fail = f; tick = t;
    @(negedge clk);
    start = 0; pass = 0; fail = 0; tick = 0;
  endtask

  task automatic wait_play(input string nm);
    for (int i = 0; i < 10 && !playing && !game_over; i++)
      @(negedge clk);
    if (!playing && !game_over) begin
      nvec++;
      nerr++;
      $display("FAIL %s: timeout waiting for PLAY", nm);
    end
  endtask

  task automatic new_game();
    if (game_over) begin
      pulse(1, 0, 0, 0);
      @(negedge clk);
    end
    pulse(1, 0, 0, 0);
    wait_play("new_game");
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".addr"}, int'(word_addr), 0);
    chk({nm, ".cword"}, int'(cword), 0);
    chk({nm, ".chk_clr"}, int'(chk_clr), 0);
    chk({nm, ".score"}, int'(score), 0);
    chk({nm, ".lives"}, int'(lives), LV);
    chk({nm, ".time"}, int'(time_left), T_RST);
    chk({nm, ".playing"}, int'(playing), 0);
    chk({nm, ".over"}, int'(game_over), 0);
  endtask

  initial begin
    mem[0] = 20'h12345;
    mem[1] = 20'h6789A;
    mem[2] = 20'hBCDEF;
    mem[3] = 20'h0F1E2;

    tbl[0]  = '{OP_PASS,  1, 3, 1, 1, 0};
    tbl[1]  = '{OP_PASS,  2, 3, 2, 1, 0};
    tbl[2]  = '{OP_PASS,  3, 3, 3, 1, 0};
    tbl[3]  = '{OP_PASS,  4, 3, 0, 1, 0};
    tbl[4]  = '{OP_PASS,  5, 3, 1, 1, 0};
    tbl[5]  = '{OP_BOTH,  5, 2, 2, 1, 0};
    tbl[6]  = '{OP_FAIL,  5, 1, 3, 1, 0};
    tbl[7]  = '{OP_FAIL,  5, 0, 3, 0, 1};
    tbl[8]  = '{OP_START, 5, 0, 3, 0, 0};
    tbl[9]  = '{OP_START, 0, 3, 3, 1, 0};
    tbl[10] = '{OP_FAIL,  0, 2, 0, 1, 0};
    tbl[11] = '{OP_FAIL,  0, 1, 1, 1, 0};
    tbl[12] = '{OP_FAIL,  0, 0, 1, 0, 1};

    rst_n = 0; start = 0; tick = 0; pass = 0; fail = 0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1;
    @(negedge clk);

    start = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 0;
      chk($sformatf("lat.chk_clr@%0d", c),
          int'(chk_clr), (c == 2) ? 1 : 0);
      chk($sformatf("lat.playing@%0d", c),
          int'(playing), (c >= 3) ? 1 : 0);
    end
    chk("lat.cword", int'(cword), int'(mem[0]));

    for (int i = 0; i < 13; i++) begin
      unique case (tbl[i].op)
        OP_START: pulse(1, 0, 0, 0);
        OP_PASS:  pulse(0, 1, 0, 0);
        OP_FAIL:  pulse(0, 0, 1, 0);
        OP_BOTH:  pulse(0, 1, 1, 0);
      endcase
      if (tbl[i].play == 1)
        wait_play($sformatf("v%0d", i));
      else
        repeat (2) @(negedge clk);
      chk($sformatf("v%0d.score", i),
          int'(score), tbl[i].score);
      chk($sformatf("v%0d.lives", i),
          int'(lives), tbl[i].lives);
      chk($sformatf("v%0d.addr", i),
          int'(word_addr), tbl[i].addr);
      chk($sformatf("v%0d.playing", i),
          int'(playing), tbl[i].play);
      chk($sformatf("v%0d.over", i),
          int'(game_over), tbl[i].over);
      if (tbl[i].play == 1)
        chk($sformatf("v%0d.cword", i),
            int'(cword), int'(mem[tbl[i].addr]));
    end

`ifdef ROUND_CTRL_TIMER_EN
    new_game();
    chk("tmr.load", int'(time_left), 2);
    pulse(0, 0, 0, 1);
    chk("tmr.t1", int'(time_left), 1);
    chk("tmr.t1.playing", int'(playing), 1);
    pulse(0, 0, 0, 1);
    chk("tmr.t0", int'(time_left), 0);
    chk("tmr.t0.over", int'(game_over), 1);
    chk("tmr.t0.playing", int'(playing), 0);
    repeat (2) @(negedge clk);
    chk("tmr.hold.over", int'(game_over), 1);

    new_game();
    chk("tp.score0", int'(score), 0);
    pulse(0, 0, 0, 1);
    chk("tp.t1", int'(time_left), 1);
    pulse(0, 1, 0, 1);
    chk("tp.score", int'(score), 1);
    chk("tp.over", int'(game_over), 1);
    chk("tp.time", int'(time_left), 0);
`else
    new_game();
    for (int k = 0; k < 3; k++) begin
      pulse(0, 0, 0, 1);
      @(negedge clk);
    end
    chk("notmr.time", int'(time_left), 0);
    chk("notmr.playing", int'(playing), 1);
`endif

    if (!playing) new_game();
    pulse(0, 1, 0, 0);
    wait_play("rst.pass");
    chk("rst.pre.score", int'(score), 1);
    rst_n = 0;
    @(negedge clk);
    chk_reset("rst.mid");
    rst_n = 1;
    @(negedge clk);
    chk("rst.post.chk_clr", int'(chk_clr), 0);
    chk("rst.post.playing", int'(playing), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 SHALL have parameter NWORDS, default 32: number of words in word store, power of two, 2..64.
REQ-002 SHALL have parameter LIVES, default 3: fails allowed per game, 1..3.
REQ-003 SHALL have parameter ROUND_SECS, default 60: game duration in tick pulses, 1..127.
REQ-004 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1: single-cycle request to begin a game.
REQ-007 SHALL have port tick  input  1: single-cycle 1 Hz strobe.
REQ-008 SHALL have port pass  input  1: word-completed pulse from checker.
REQ-009 SHALL have port fail  input  1: wrong-letter pulse from checker.
REQ-010 SHALL have port word_data  input  20: four 5-bit letter codes, valid one cycle after word_addr.
REQ-011 SHALL have port word_addr  output  log2(NWORDS): word store index.
REQ-012 SHALL have port cword  output  20: word presented to checker.
REQ-013 SHALL have port chk_clr  output  1: one-cycle pulse returning checker to first letter.
REQ-014 SHALL have port score  output  6: words passed this game.
REQ-015 SHALL have port lives  output  2: remaining lives.
REQ-016 SHALL have port time_left  output  7: seconds remaining.
REQ-017 SHALL have port playing  output  1: high only in PLAY.
REQ-018 SHALL have port game_over  output  1: high in DONE.

Function
REQ-019 SHALL implement states IDLE, FETCH, LATCH, PLAY, DONE.
REQ-020 SHALL go IDLE->FETCH on start: score=0, lives=LIVES, time_left=ROUND_SECS, word_addr unchanged.
REQ-021 SHALL go FETCH->LATCH after exactly one cycle; LATCH captures word_data into cword, pulses chk_clr, goes to PLAY.
REQ-022 SHALL give start-to-playing latency of 3 cycles.
REQ-023 SHALL in PLAY on pass: score+1 (saturating at 63), word_addr+1 (wraps NWORDS-1 to 0), go FETCH.
REQ-024 SHALL in PLAY on fail: lives-1; if lives was 1, go DONE; else word_addr+1, go FETCH.
REQ-025 SHALL treat pass and fail in the same cycle as fail only.
REQ-026 SHALL ignore pass/fail outside PLAY.
REQ-027 SHALL on tick in any state except IDLE/DONE decrement time_left, stopping at 0; at 0, go DONE.
REQ-028 SHALL when tick reaching 0 coincides with pass, count the pass, then go DONE.
REQ-029 SHALL go DONE->IDLE on start, holding score, lives, time_left until the next game begins.
REQ-030 SHALL ignore start in FETCH, LATCH and PLAY.

Reset
REQ-031 SHALL on rst_n low at clk edge: state IDLE, word_addr 0, cword 0, chk_clr 0, score 0, lives LIVES, time_left ROUND_SECS, playing 0, game_over 0.
REQ-032 SHALL let reset mid-game abandon the game with no chk_clr pulse.

Configuration
REQ-033 SHALL honour macro ROUND_CTRL_TIMER_EN: defined means REQ-027/028 apply; undefined means tick ignored, time_left held at 0, game ends only on lives exhausted.

Structure
REQ-034 SHALL put the state encoding, LETTER_W=5, WORD_W=20 in shared package round_ctrl_pkg.
REQ-035 SHALL put the time_left down-counter in sub-module round_timer (load, tick, expire).

Verification
REQ-036 SHALL cover: reset, start -> playing at cycle 3, chk_clr one pulse at cycle 2, cword=word_data[addr 0].
REQ-037 SHALL cover: 3 passes -> score 3, word_addr 3; NWORDS=4 with 5 passes -> word_addr wraps to 1.
REQ-038 SHALL cover: LIVES=3, 3 fails -> lives 0, game_over 1, score unchanged.
REQ-039 SHALL cover: pass and fail same cycle -> lives-1, score unchanged.
REQ-040 SHALL cover, with timer enabled and ROUND_SECS=2: 2 ticks -> DONE, time_left 0; final tick coincident with pass -> score+1 and DONE.
REQ-041 SHALL cover: rst_n low during PLAY -> all outputs to reset values next cycle.
